// File: rtl/bs_pkg.sv
// Shared widths and types for the bitstream bit reader.
package bs_pkg;

  localparam int BS_WORD_BITS = 64;
  localparam int BS_PEEK_BITS = 32;
  localparam int BS_BUF_BITS  = 128;

  typedef logic [5:0] bs_len_t;

endpackage

// File: rtl/bs_bit_reader.sv
// 64-bit FIFO word to MSB-first bit reader with a 32-bit peek window and 0..32-bit consume.
// Optional BS_BYTE_ALIGN_EN adds a byte_align input that skips to the next byte boundary.
module bs_bit_reader
  import bs_pkg::*;
#(
  parameter int DATA_BITS = BS_WORD_BITS,
  parameter int PEEK_BITS = BS_PEEK_BITS,
  parameter int BUF_BITS  = BS_BUF_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 fifo_rd,
  input  logic [DATA_BITS-1:0] fifo_rd_data,
  input  logic                 fifo_empty,
  input  logic                 flush,
  input  logic                 consume_en,
  input  bs_len_t              consume_len,
`ifdef BS_BYTE_ALIGN_EN
  input  logic                 byte_align,
`endif
  output logic [PEEK_BITS-1:0] peek_data,
  output logic                 peek_valid,
  output logic [7:0]           bits_avail,
  output logic [31:0]          bit_pos,
  output logic                 underrun_err
);

  localparam logic [7:0] WORD_LEN = 8'(DATA_BITS);
  localparam logic [7:0] PEEK_LEN = 8'(PEEK_BITS);

  logic [BUF_BITS-1:0] shift_buf, shifted, buf_next;
  logic [7:0]          cnt, cnt_after, cnt_next;
  logic [7:0]          req_len, eff_len;
  logic [8:0]          proj;
  logic                inflight, bad_req, over, valid_q;

  always_comb begin
    req_len = consume_en ? {2'b00, consume_len} : 8'd0;
    bad_req = 1'b0;
`ifdef BS_BYTE_ALIGN_EN
    if (byte_align) begin
      if (consume_en) bad_req = 1'b1;
      else            req_len = {5'b00000, (3'd0 - bit_pos[2:0])};
    end
`endif
    // A rejected consume leaves the buffer untouched but still allows fetch/append.
    over      = bad_req | (req_len > cnt) | (req_len > PEEK_LEN);
    eff_len   = over ? 8'd0 : req_len;
    cnt_after = cnt - eff_len;
    proj      = {1'b0, cnt_after} + (inflight ? {1'b0, WORD_LEN} : 9'd0);
    fifo_rd   = rst_n & ~fifo_empty & ~flush & (proj <= {1'b0, WORD_LEN});
    shifted   = shift_buf << eff_len;
    buf_next  = shifted;
    cnt_next  = cnt_after;
    if (inflight) begin
      buf_next = shifted | ({fifo_rd_data, {DATA_BITS{1'b0}}} >> cnt_after);
      cnt_next = cnt_after + WORD_LEN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_buf    <= '0;
      cnt          <= 8'd0;
      inflight     <= 1'b0;
      bit_pos      <= 32'd0;
      underrun_err <= 1'b0;
      valid_q      <= 1'b0;
    end else if (flush) begin
      shift_buf    <= '0;
      cnt          <= 8'd0;
      inflight     <= 1'b0;
      bit_pos      <= 32'd0;
      underrun_err <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      shift_buf <= buf_next;
      cnt       <= cnt_next;
      inflight  <= fifo_rd;
      bit_pos   <= bit_pos + {24'd0, eff_len};
      valid_q   <= (cnt_next >= PEEK_LEN);
      if (over) underrun_err <= 1'b1;
    end
  end

  assign peek_data  = shift_buf[BUF_BITS-1 -: PEEK_BITS];
  assign peek_valid = valid_q;
  assign bits_avail = cnt;

endmodule

// File: tb/tb_bs_bit_reader.sv
// Directed self-checking bench for bs_bit_reader with a small behavioural FIFO in front.
module tb_bs_bit_reader;
  import bs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_rd;
  logic [63:0] fifo_rd_data = 64'd0;
  logic        fifo_empty;
  logic        flush;
  logic        consume_en;
  bs_len_t     consume_len;
`ifdef BS_BYTE_ALIGN_EN
  logic        byte_align;
`endif
  logic [31:0] peek_data;
  logic        peek_valid;
  logic [7:0]  bits_avail;
  logic [31:0] bit_pos;
  logic        underrun_err;

  int n_checks = 0;
  int n_errors = 0;
  int rd_empty_viol = 0;

  logic [63:0] mem [64];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [63:0] words [16];

  always #5 clk = ~clk;

  bs_bit_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_rd      (fifo_rd),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .flush        (flush),
    .consume_en   (consume_en),
    .consume_len  (consume_len),
`ifdef BS_BYTE_ALIGN_EN
    .byte_align   (byte_align),
`endif
    .peek_data    (peek_data),
    .peek_valid   (peek_valid),
    .bits_avail   (bits_avail),
    .bit_pos      (bit_pos),
    .underrun_err (underrun_err)
  );

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_rd_data <= mem[rd_ptr % 64];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (fifo_rd && fifo_empty) rd_empty_viol++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [63:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic consume(input int len);
    consume_en  = (len != 0);
    consume_len = bs_len_t'(len);
  endtask

  initial begin
    logic [63:0] wa, wb, w;
    logic [31:0] exp_peek;
    bit          primed;

    rst_n = 1'b0; flush = 1'b0; consume_en = 1'b0; consume_len = '0;
`ifdef BS_BYTE_ALIGN_EN
    byte_align = 1'b0;
`endif
    push(64'h0123456789ABCDEF);
    push(64'hFEDCBA9876543210);
    repeat (2) @(negedge clk);
    chk("rst_peek", 64'(peek_data), 64'd0);
    chk("rst_valid", 64'(peek_valid), 64'd0);
    chk("rst_avail", 64'(bits_avail), 64'd0);
    chk("rst_bitpos", 64'(bit_pos), 64'd0);
    chk("rst_err", 64'(underrun_err), 64'd0);
    chk("rst_rd", 64'(fifo_rd), 64'd0);

    // Startup: two back-to-back reads, buffer full at T+3
    rst_n = 1'b1;
    #1 chk("rd_T", 64'(fifo_rd), 64'd1);
    @(negedge clk); chk("rd_T1", 64'(fifo_rd), 64'd1);
    @(negedge clk); chk("rd_T2", 64'(fifo_rd), 64'd0);
    chk("valid_T2", 64'(peek_valid), 64'd1);
    @(negedge clk);
    chk("peek_T3", 64'(peek_data), 64'h01234567);
    chk("avail_T3", 64'(bits_avail), 64'd128);

    consume(4);
    @(negedge clk); chk("peek_c4", 64'(peek_data), 64'h12345678);
    consume(28);
    @(negedge clk); chk("peek_c28", 64'(peek_data), 64'h89ABCDEF);
    consume(32);
    @(negedge clk); chk("peek_c32", 64'(peek_data), 64'hFEDCBA98);
    chk("bitpos_64", 64'(bit_pos), 64'd64);
    chk("avail_64", 64'(bits_avail), 64'd64);
    consume(32);
    @(negedge clk); chk("peek_w1lo", 64'(peek_data), 64'h76543210);
    consume(22);
    @(negedge clk); chk("avail_10", 64'(bits_avail), 64'd10);
    chk("peek_10", 64'(peek_data), 64'h84000000);
    chk("bitpos_118", 64'(bit_pos), 64'd118);
    consume(11);
    @(negedge clk); chk("under_err", 64'(underrun_err), 64'd1);
    chk("under_avail", 64'(bits_avail), 64'd10);
    chk("under_bitpos", 64'(bit_pos), 64'd118);
    consume(10);
    @(negedge clk); chk("drain_avail", 64'(bits_avail), 64'd0);
    chk("drain_valid", 64'(peek_valid), 64'd0);
    chk("drain_bitpos", 64'(bit_pos), 64'd128);
    chk("err_sticky", 64'(underrun_err), 64'd1);
    consume(0); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush_err", 64'(underrun_err), 64'd0);
    chk("flush_bitpos", 64'(bit_pos), 64'd0);

    // Sustained 32 bits/cycle over 16 words
    for (int i = 0; i < 16; i++) begin
      w = {$urandom, $urandom};
      words[i] = w;
      push(w);
    end
    primed = 1'b0;
    for (int c = 0; c < 20 && !primed; c++) begin
      @(negedge clk);
      primed = peek_valid;
    end
    chk("prime", 64'(primed), 64'd1);
    for (int k = 0; k < 32; k++) begin
      w = words[k / 2];
      exp_peek = (k % 2 == 0) ? w[63:32] : w[31:0];
      chk("stream_valid", 64'(peek_valid), 64'd1);
      chk("stream_peek", 64'(peek_data), 64'(exp_peek));
      consume(32);
      @(negedge clk);
    end
    consume(0);
    chk("stream_avail", 64'(bits_avail), 64'd0);
    chk("stream_bitpos", 64'(bit_pos), 64'd1024);

    // Flush while a word is in flight: it is dropped, next word lands at offset 0
    wa = 64'hA5A55A5A0F0FF0F0;
    wb = 64'h13579BDF2468ACE0;
    push(wa); push(wb);
    #1 chk("fl_rd", 64'(fifo_rd), 64'd1);
    @(negedge clk); flush = 1'b1;
    #1 chk("fl_rd_gated", 64'(fifo_rd), 64'd0);
    @(negedge clk); flush = 1'b0;
    chk("fl_avail", 64'(bits_avail), 64'd0);
    chk("fl_bitpos", 64'(bit_pos), 64'd0);
    chk("fl_peek", 64'(peek_data), 64'd0);
    repeat (2) @(negedge clk);
    chk("fl_next_peek", 64'(peek_data), 64'h13579BDF);
    chk("fl_next_avail", 64'(bits_avail), 64'd64);

    // Byte alignment from bit_pos 13
    consume(13);
    @(negedge clk); consume(0);
    chk("align_pre", 64'(bit_pos), 64'd13);
`ifdef BS_BYTE_ALIGN_EN
    byte_align = 1'b1;
    @(negedge clk); byte_align = 1'b0;
`else
    consume(3);
    @(negedge clk); consume(0);
`endif
    chk("align_bitpos", 64'(bit_pos), 64'd16);
    chk("align_peek", 64'(peek_data), 64'h9BDF2468);
    chk("align_avail", 64'(bits_avail), 64'd48);

    // Over-length request with enough bits buffered is still rejected
    consume(33);
    @(negedge clk); consume(0);
    chk("len33_err", 64'(underrun_err), 64'd1);
    chk("len33_avail", 64'(bits_avail), 64'd48);
    chk("len33_bitpos", 64'(bit_pos), 64'd16);

    rst_n = 1'b0;
    #1 chk("mid_rst_avail", 64'(bits_avail), 64'd0);
    chk("mid_rst_err", 64'(underrun_err), 64'd0);
    chk("mid_rst_bitpos", 64'(bit_pos), 64'd0);
    chk("mid_rst_peek", 64'(peek_data), 64'd0);
    chk("rd_while_empty", 64'(rd_empty_viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
